// File: rtl/store_write_buffer_if.sv
// Store-queue / write-bus bundle for store_write_buffer.
// slave = the buffer itself, master = store queue plus bus environment.
interface store_write_buffer_if;
  logic        sq_valid;
  logic [31:0] sq_addr;
  logic [3:0]  sq_be;
  logic [31:0] sq_data;
  logic        sq_pop;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_ack;
  logic        empty;
  logic        drained;

  modport slave (
    input  sq_valid, sq_addr, sq_be, sq_data, bus_ready, bus_ack,
    output sq_pop, bus_req, bus_addr, bus_be, bus_wdata, empty, drained
  );

  modport master (
    output sq_valid, sq_addr, sq_be, sq_data, bus_ready, bus_ack,
    input  sq_pop, bus_req, bus_addr, bus_be, bus_wdata, empty, drained
  );
endinterface

// File: rtl/store_write_buffer.sv
// In-order store write buffer: circular FIFO between store queue and write bus,
// with a cap on unacknowledged writes. Define STORE_WRITE_BUFFER_MERGE_EN to merge same-word stores into the tail.
module store_write_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                clk,
  input logic                rst,
  store_write_buffer_if.slave sif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, tail_idx;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   out_q, out_d;
  logic            rst_dly_q, rst_dly_d;
  logic            rst_hold, empty_int, req, issue, merge_hit, pop, push, wr_en;
  logic [PW-1:0]   wr_idx;
  entry_t          wr_entry;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^sif.sq_addr[1:0];

  // NOTE: combinational logic uses blocking '=' and every output gets a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    rst_dly_d = rst;
    // Handshakes stay quiet through the reset cycle and the one after it.
    rst_hold  = rst | rst_dly_q;
    empty_int = (count_q == '0);
    req       = ~rst_hold & ~empty_int & (out_q < MAX_C);
    issue     = req & sif.bus_ready;
    tail_idx  = tail_q - PW'(1);

`ifdef STORE_WRITE_BUFFER_MERGE_EN
    // The tail equals the head when count is 1; never modify an entry leaving this cycle.
    merge_hit = sif.sq_valid & (|sif.sq_be) & ~empty_int
              & (mem_q[tail_idx].addr == sif.sq_addr[31:2])
              & ~(issue & (count_q == CW'(1)));
`else
    merge_hit = 1'b0;
`endif

    pop   = ~rst_hold & sif.sq_valid & ((count_q < DEPTH_C) | merge_hit);
    push  = pop & (|sif.sq_be) & ~merge_hit;
    wr_en = push | (pop & merge_hit);

    wr_idx   = merge_hit ? tail_idx : tail_q;
    wr_entry = merge_hit ? mem_q[tail_idx] : '{addr: sif.sq_addr[31:2], be: 4'b0, data: 32'b0};
    wr_entry.be = wr_entry.be | sif.sq_be;
    for (int b = 0; b < 4; b++) begin
      if (sif.sq_be[b]) wr_entry.data[8*b +: 8] = sif.sq_data[8*b +: 8];
    end

    head_d  = issue ? head_q + PW'(1) : head_q;
    tail_d  = push  ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (push && !issue)      count_d = count_q + CW'(1);
    else if (issue && !push) count_d = count_q - CW'(1);
    out_d = out_q;
    if (issue && !(sif.bus_ack && out_q != '0))      out_d = out_q + OW'(1);
    else if (!issue && sif.bus_ack && out_q != '0)   out_d = out_q - OW'(1);

    sif.sq_pop    = pop;
    sif.bus_req   = req;
    sif.bus_addr  = mem_q[head_q].addr;
    sif.bus_be    = mem_q[head_q].be;
    sif.bus_wdata = mem_q[head_q].data;
    sif.empty     = rst | empty_int;
    sif.drained   = rst | (empty_int & (out_q == '0));
  end

  always_ff @(posedge clk) begin
    rst_dly_q <= rst_dly_d;
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count/pointers alone define
  // which entries are live, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_entry;
  end

  ack_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(sif.bus_ack && out_q == '0));
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  store_write_buffer_if swb();

  store_write_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .sif (swb)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];
  int   m_out  = 0;
  bit   m_post = 1'b0;
  int   n_obs_pop = 0;
  int   n_obs_issue = 0;
  logic obs_pop, obs_req, obs_empty, obs_drained, obs_issue;
  logic [29:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    swb.sq_valid = 1'b0; swb.sq_addr = '0; swb.sq_be = '0; swb.sq_data = '0;
    swb.bus_ready = 1'b0; swb.bus_ack = 1'b0;
  endtask

  // Called just after a falling edge with inputs set; checks and advances one cycle.
  task automatic step();
    bit e_empty, e_req, e_issue, merge, e_pop;
    ent_t t;
    #1;
    obs_pop = swb.sq_pop;   obs_req = swb.bus_req;
    obs_empty = swb.empty;  obs_drained = swb.drained;
    obs_addr = swb.bus_addr; obs_be = swb.bus_be; obs_wdata = swb.bus_wdata;
    obs_issue = obs_req & swb.bus_ready;
    n_obs_pop   += int'(obs_pop);
    n_obs_issue += int'(obs_issue);
    if (rst || m_post) begin
      check("rst_pop", obs_pop, 0);
      check("rst_req", obs_req, 0);
      check("rst_empty", obs_empty, 1);
      check("rst_drained", obs_drained, 1);
      if (rst) begin mq.delete(); m_out = 0; m_post = 1'b1; end
      else m_post = 1'b0;
    end else begin
      e_empty = (mq.size() == 0);
      e_req   = !e_empty && (m_out < MAXO);
      e_issue = e_req && swb.bus_ready;
      merge   = 1'b0;
`ifdef STORE_WRITE_BUFFER_MERGE_EN
      merge = swb.sq_valid && (swb.sq_be != 0) && !e_empty
           && (mq[mq.size()-1].addr == swb.sq_addr[31:2])
           && !(e_issue && mq.size() == 1);
`endif
      e_pop = swb.sq_valid && ((mq.size() < DEPTH) || merge);
      check("sq_pop", obs_pop, e_pop);
      check("bus_req", obs_req, e_req);
      check("empty", obs_empty, e_empty);
      check("drained", obs_drained, e_empty && m_out == 0);
      if (e_req) begin
        check("bus_addr", obs_addr, mq[0].addr);
        check("bus_be", obs_be, mq[0].be);
        check("bus_wdata", obs_wdata, mq[0].data);
      end
      if (e_pop && swb.sq_be != 0 && merge) begin
        t = mq[mq.size()-1];
        for (int b = 0; b < 4; b++)
          if (swb.sq_be[b]) t.data[8*b +: 8] = swb.sq_data[8*b +: 8];
        t.be = t.be | swb.sq_be;
        mq[mq.size()-1] = t;
      end
      if (e_issue) begin void'(mq.pop_front()); m_out++; end
      if (swb.bus_ack) m_out--;
      if (e_pop && swb.sq_be != 0 && !merge) begin
        t.addr = swb.sq_addr[31:2]; t.be = swb.sq_be; t.data = '0;
        for (int b = 0; b < 4; b++)
          if (swb.sq_be[b]) t.data[8*b +: 8] = swb.sq_data[8*b +: 8];
        mq.push_back(t);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step();
    idle(); step();
  endtask

  task automatic push_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input logic rdy);
    idle();
    swb.sq_valid = 1'b1; swb.sq_addr = a; swb.sq_be = be; swb.sq_data = d; swb.bus_ready = rdy;
    step();
  endtask

  initial begin
    int p0, i0, n_wr;
    bit got_first;
    logic [3:0] first_be;
    logic [31:0] first_data;
    idle();
    @(negedge clk);

    // Single store: one-cycle latency, word address, drained after ack.
    do_reset();
    push_store(32'h100, 4'hF, 32'hDEADBEEF, 1'b1);
    check("t1_pop", obs_pop, 1);
    idle(); swb.bus_ready = 1'b1; step();
    check("t1_req", obs_req, 1);
    check("t1_addr", obs_addr, 30'h40);
    check("t1_wdata", obs_wdata, 32'hDEADBEEF);
    idle(); swb.bus_ack = 1'b1; step();
    idle(); step();
    check("t1_drained", obs_drained, 1);

    // Full buffer stalls the store queue; release drains in order.
    do_reset();
    p0 = n_obs_pop;
    for (int c = 0; c < 8; c++)
      push_store(32'h1000 + 32'((n_obs_pop - p0) * 4), 4'hF, $urandom, 1'b0);
    check("t2_pops", n_obs_pop - p0, DEPTH);
    check("t2_stall", obs_pop, 0);
    i0 = n_obs_issue;
    for (int c = 0; c < 12; c++) begin
      idle(); swb.bus_ready = 1'b1; swb.bus_ack = (m_out > 0); step();
    end
    check("t2_issues", n_obs_issue - i0, DEPTH);
    check("t2_empty", obs_empty, 1);

    // Outstanding limit.
    do_reset();
    for (int c = 0; c < 3; c++) push_store(32'h2000 + 32'(c * 4), 4'hF, $urandom, 1'b0);
    i0 = n_obs_issue;
    for (int c = 0; c < 4; c++) begin idle(); swb.bus_ready = 1'b1; step(); end
    check("t3_issues", n_obs_issue - i0, MAXO);
    check("t3_req_low", obs_req, 0);
    idle(); swb.bus_ready = 1'b1; swb.bus_ack = 1'b1; step();
    idle(); swb.bus_ready = 1'b1; step();
    check("t3_third_req", obs_req, 1);
    check("t3_issues2", n_obs_issue - i0, MAXO + 1);

    // Zero byte enables: consumed from the store queue but never buffered.
    do_reset();
    push_store(32'h400, 4'h0, 32'h12345678, 1'b1);
    check("t4_pop", obs_pop, 1);
    idle(); swb.bus_ready = 1'b1; step();
    check("t4_req", obs_req, 0);
    check("t4_empty", obs_empty, 1);

    // Same-word stores: merged into one write when merging is built in.
    do_reset();
    push_store(32'h200, 4'h1, 32'h000000AA, 1'b0);
    push_store(32'h203, 4'h8, 32'hBB000000, 1'b0);
    check("t5_pop2", obs_pop, 1);
    i0 = n_obs_issue; got_first = 1'b0; first_be = '0; first_data = '0;
    for (int c = 0; c < 6; c++) begin
      idle(); swb.bus_ready = 1'b1; swb.bus_ack = (m_out > 0); step();
      if (obs_issue && !got_first) begin
        got_first = 1'b1; first_be = obs_be; first_data = obs_wdata;
      end
    end
    n_wr = n_obs_issue - i0;
`ifdef STORE_WRITE_BUFFER_MERGE_EN
    check("t5_writes", n_wr, 1);
    check("t5_be", first_be, 4'h9);
    check("t5_wdata", first_data, 32'hBB0000AA);
`else
    check("t5_writes", n_wr, 2);
    check("t5_be", first_be, 4'h1);
    check("t5_wdata", first_data, 32'h000000AA);
`endif

    // Random traffic against the model, with occasional mid-stream resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      swb.sq_valid  = ($urandom_range(0, 2) != 0);
      swb.sq_addr   = 32'h300 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      swb.sq_be     = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      swb.sq_data   = $urandom;
      swb.bus_ready = 1'($urandom_range(0, 1));
      swb.bus_ack   = (m_out > 0 && !m_post && !rst) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
